param_mealy_fsm: RTL and testbench
==================================

PARAM_MEALY_FSM -- requirements
Module: param_mealy_fsm

Parameters
REQ-001 IN_W, 2, input vector width; the table has 2^IN_W columns per state.
REQ-002 OUT_W, 3, Mealy output vector width.
REQ-003 ST_W, 3, state register width.
REQ-004 NUM_ST, 5, number of legal states, 2..2^ST_W; legal states are 0..NUM_ST-1.
REQ-005 ACC_ST, 4, accept state, must be < NUM_ST.

Interface
REQ-006 clk  in  1  single clock; all state changes on the rising edge.
REQ-007 res  in  1  synchronous, active-high reset.
REQ-008 en  in  1  step enable; the state advances only when high.
REQ-009 x  in  IN_W  input symbol.
REQ-010 t  out  OUT_W  Mealy outputs, combinational from the current state and x.
REQ-011 state  out  ST_W  current state register.
REQ-012 acc  out  1  registered pulse; high for one cycle after each step that enters ACC_ST.
REQ-013 cfg_we  in  1  table write strobe.
REQ-014 cfg_addr  in  ST_W+IN_W  table index {state, x}.
REQ-015 cfg_data  in  ST_W+OUT_W  table entry {next_state, outputs}.
REQ-016 cfg_err  out  1  registered pulse flagging a rejected write.
REQ-017 steps  out  16  count of executed steps.

Function
REQ-018 The table has NUM_ST*2^IN_W entries, held in flops.
- Entry [s][v] holds next_state and outputs.
REQ-019 t = outputs field of entry [state][x], continuously.
- t is independent of en.
REQ-020 Step on an edge with en=1: state <= next_state of entry [state][x].
REQ-020a On that step, steps increments by 1; it wraps from 0xFFFF to 0.
REQ-021 With en=0, state and steps hold.
REQ-021a With en=0, acc is 0 on the next cycle.
REQ-022 acc is high on the cycle after a step whose next_state equals ACC_ST.
- A self-loop on ACC_ST re-pulses acc on every such step.
REQ-023 A write with cfg_we=1 updates the addressed entry at the edge, unless it is rejected.
REQ-023a A write is rejected when cfg_addr state field >= NUM_ST.
REQ-023b A write is also rejected when cfg_data next_state field >= NUM_ST.
REQ-023c A rejected write leaves the table unchanged and sets cfg_err=1 for the next cycle; otherwise cfg_err=0.
REQ-024 A write and a step on the same edge both take effect.
- The step uses the pre-write entry value, even when it targets the same entry.
- t reflects the new entry from the following cycle.
REQ-025 If state >= NUM_ST, t=0.
- The next edge forces state=0 regardless of en.
- That edge does not increment steps.
REQ-026 Width rules: all fields are unsigned.
- No arithmetic on state; steps is a modulo-2^16 counter.

Reset
REQ-027 res=1 at an edge sets state=0, steps=0, acc=0, cfg_err=0, and every table entry to 0 (next_state 0, outputs 0).
REQ-028 Reset has priority over en and cfg_we on the same edge.
- A concurrent write is discarded.
- No cfg_err is raised for it.
REQ-029 Reset mid-run takes effect at that edge.
- t=0 from the following cycle.

Verification
REQ-030 Reset then idle:
- Stimulus: res=1 for one edge, then en=1, x=2'b11 for 3 edges.
- Required: state=0 and t=3'b000 throughout; steps=3 after the third edge; acc=0.
REQ-031 Program and walk:
- Stimulus: write {0,01}<-{1,3'b110}, {1,01}<-{4,3'b011}; then en=1, x=01.
- Required: t=110 in state 0 and state=1 after one edge; t=011 in state 1 and state=4 after the next edge; acc=1 on the following cycle only; steps=2.
REQ-032 Rejected writes:
- Stimulus: a write with cfg_addr state=5, then a write with next_state=7.
- Required: cfg_err=1 the cycle after each; the table is unchanged (read back via t).
REQ-033 Write/step collision:
- Stimulus: in state 0 with x=01, entry {1,110}; write {0,01}<-{2,001} on the same edge as en=1.
- Required: state=1 (old entry used); a later return to state 0 with x=01 shows t=001.
REQ-034 Hold, wrap and reset priority:
- Stimulus: en=0 for 5 edges; then preload steps to 0xFFFF via 65535 steps and step once; then res=1 with cfg_we=1 on the same edge.
- Required: state and steps frozen while en=0; steps=0 after the wrapping step; after the reset edge all entries are 0 and cfg_err=0.

Source files
------------

// File: rtl/param_mealy_fsm_if.sv
// Configuration bus for the table-driven Mealy machine: table write port
// plus the rejected-write flag returned by the machine.
interface param_mealy_fsm_if #(
  parameter int ST_W  = 3,
  parameter int IN_W  = 2,
  parameter int OUT_W = 3
);
  logic                  cfg_we;
  logic [ST_W+IN_W-1:0]  cfg_addr;
  logic [ST_W+OUT_W-1:0] cfg_data;
  logic                  cfg_err;

  modport master (
    output cfg_we,
    output cfg_addr,
    output cfg_data,
    input  cfg_err
  );

  modport slave (
    input  cfg_we,
    input  cfg_addr,
    input  cfg_data,
    output cfg_err
  );
endinterface

// File: rtl/param_mealy_fsm.sv
// Table-driven Mealy machine: a flop-based transition/output table, indexed by
// {state, x}, is programmed over the cfg bus and stepped whenever en is high.
//
// state          | meaning
// 0              | home state after reset or after recovery from an illegal state
// 1..NUM_ST-1    | legal programmable states
// ACC_ST         | accept state; every step into it pulses acc
// NUM_ST..max    | illegal; outputs forced to 0, next edge returns to 0
module param_mealy_fsm #(
  parameter int IN_W   = 2,
  parameter int OUT_W  = 3,
  parameter int ST_W   = 3,
  parameter int NUM_ST = 5,
  parameter int ACC_ST = 4
) (
  input  logic                 clk,
  input  logic                 res,
  input  logic                 en,
  input  logic [IN_W-1:0]      x,
  output logic [OUT_W-1:0]     t,
  output logic [ST_W-1:0]      state,
  output logic                 acc,
  output logic [15:0]          steps,
  param_mealy_fsm_if.slave     cfg
);

  localparam int IDX_W   = ST_W + IN_W;
  localparam int ENT_W   = ST_W + OUT_W;
  localparam int NUM_ENT = NUM_ST * (2 ** IN_W);

  // One extra bit so NUM_ST == 2**ST_W still compares correctly.
  localparam logic [ST_W:0]   NUM_ST_X = (ST_W+1)'(NUM_ST);
  localparam logic [ST_W-1:0] ACC_V    = ST_W'(ACC_ST);

  logic [ENT_W-1:0] tbl [NUM_ENT];

  logic             st_legal;
  logic [IDX_W-1:0] cur_idx;
  logic [ENT_W-1:0] cur_ent;
  logic [ST_W-1:0]  nxt_st;
  logic [ST_W-1:0]  wr_st;
  logic [ST_W-1:0]  wr_nxt;
  logic             wr_ok;

  always_comb begin
    st_legal = ({1'b0, state} < NUM_ST_X);
    cur_idx  = {state, x};
    cur_ent  = '0;
    if (st_legal) begin
      cur_ent = tbl[cur_idx];
    end
    nxt_st   = cur_ent[ENT_W-1:OUT_W];
    t        = cur_ent[OUT_W-1:0];
  end

  always_comb begin
    wr_st  = cfg.cfg_addr[IDX_W-1:IN_W];
    wr_nxt = cfg.cfg_data[ENT_W-1:OUT_W];
    wr_ok  = ({1'b0, wr_st} < NUM_ST_X) && ({1'b0, wr_nxt} < NUM_ST_X);
  end

  // The step reads cur_ent before the write below lands, so a same-edge
  // write to the active entry only affects later cycles.
  always_ff @(posedge clk) begin
    if (res) begin
      state       <= '0;
      steps       <= '0;
      acc         <= 1'b0;
      cfg.cfg_err <= 1'b0;
      for (int i = 0; i < NUM_ENT; i++) begin
        tbl[i] <= '0;
      end
    end else begin
      acc         <= 1'b0;
      cfg.cfg_err <= 1'b0;

      if (!st_legal) begin
        state <= '0;
      end else if (en) begin
        state <= nxt_st;
        steps <= steps + 16'd1;
        acc   <= (nxt_st == ACC_V);
      end

      if (cfg.cfg_we) begin
        if (wr_ok) begin
          tbl[cfg.cfg_addr] <= cfg.cfg_data;
        end else begin
          cfg.cfg_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_param_mealy_fsm.sv
// Scoreboard bench for param_mealy_fsm: a driver pushes the expected per-cycle
// view from an abstract table model, a monitor pops and compares each cycle.
module tb_param_mealy_fsm;

  localparam int IN_W   = 2;
  localparam int OUT_W  = 3;
  localparam int ST_W   = 3;
  localparam int NUM_ST = 5;
  localparam int ACC_ST = 4;
  localparam int NCOL   = 1 << IN_W;

  logic        clk = 1'b0;
  logic        res;
  logic        en;
  logic [1:0]  x;
  logic [2:0]  t;
  logic [2:0]  state;
  logic        acc;
  logic [15:0] steps;

  param_mealy_fsm_if #(.ST_W(ST_W), .IN_W(IN_W), .OUT_W(OUT_W)) cfg_bus ();

  param_mealy_fsm #(
    .IN_W(IN_W), .OUT_W(OUT_W), .ST_W(ST_W), .NUM_ST(NUM_ST), .ACC_ST(ACC_ST)
  ) dut (
    .clk   (clk),
    .res   (res),
    .en    (en),
    .x     (x),
    .t     (t),
    .state (state),
    .acc   (acc),
    .steps (steps),
    .cfg   (cfg_bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    int st;
    int t;
    int acc;
    int err;
    int steps;
  } exp_t;

  exp_t sb_q[$];

  int m_next [NUM_ST*NCOL];
  int m_out  [NUM_ST*NCOL];
  int m_state, m_steps, m_acc, m_err;
  bit m_valid = 1'b0;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input int req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic int ent(input int s, input int v);
    return s * NCOL + v;
  endfunction

  function automatic int dat(input int ns, input int o);
    return ns * (1 << OUT_W) + o;
  endfunction

  // One clock cycle: drive inputs, record what the outputs must show during
  // this cycle, then advance the model across the coming edge.
  task automatic cyc(input bit r, input bit e, input int xv, input bit we,
                     input int a, input int d);
    exp_t ex;
    int   ns, st, ac, er, as_st, d_ns;
    @(negedge clk);
    res              = r;
    en               = e;
    x                = xv[1:0];
    cfg_bus.cfg_we   = we;
    cfg_bus.cfg_addr = a[4:0];
    cfg_bus.cfg_data = d[5:0];

    if (m_valid) begin
      ex.st    = m_state;
      ex.t     = (m_state < NUM_ST) ? m_out[ent(m_state, xv)] : 0;
      ex.acc   = m_acc;
      ex.err   = m_err;
      ex.steps = m_steps;
      sb_q.push_back(ex);
    end

    if (r) begin
      m_state = 0; m_steps = 0; m_acc = 0; m_err = 0;
      foreach (m_next[i]) begin
        m_next[i] = 0;
        m_out[i]  = 0;
      end
      m_valid = 1'b1;
    end else begin
      ns = m_state; st = m_steps; ac = 0; er = 0;
      if (m_state >= NUM_ST) begin
        ns = 0;
      end else if (e) begin
        ns = m_next[ent(m_state, xv)];
        st = (m_steps + 1) % 65536;
        ac = (ns == ACC_ST) ? 1 : 0;
      end
      if (we) begin
        as_st = a / NCOL;
        d_ns  = d / (1 << OUT_W);
        if (as_st >= NUM_ST || d_ns >= NUM_ST) begin
          er = 1;
        end else begin
          m_next[a] = d_ns;
          m_out[a]  = d % (1 << OUT_W);
        end
      end
      m_state = ns; m_steps = st; m_acc = ac; m_err = er;
    end
  endtask

  exp_t mon_e;
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (sb_q.size() > 0) begin
        mon_e = sb_q.pop_front();
        chk("state",   {29'b0, state}, mon_e.st);
        chk("t",       {29'b0, t},     mon_e.t);
        chk("acc",     {31'b0, acc},   mon_e.acc);
        chk("cfg_err", {31'b0, cfg_bus.cfg_err}, mon_e.err);
        chk("steps",   {16'b0, steps}, mon_e.steps);
      end
    end
  end

  initial begin
    #5_000_000;
    failures++;
    $display("FAIL timeout actual=running required=finished at %0t", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    int rr, re, rx, rw, ra, rn;
    res = 1'b1; en = 1'b0; x = '0;
    cfg_bus.cfg_we = 1'b0; cfg_bus.cfg_addr = '0; cfg_bus.cfg_data = '0;

    // reset then idle stepping on an all-zero table
    cyc(1, 0, 0, 0, 0, 0);
    repeat (3) cyc(0, 1, 3, 0, 0, 0);

    // program and walk 0 -> 1 -> 4 (accept)
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 1, ent(0, 1), dat(1, 6));
    cyc(0, 0, 1, 1, ent(1, 1), dat(4, 3));
    cyc(0, 1, 1, 0, 0, 0);
    cyc(0, 1, 1, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);

    // rejected writes, then a way back to state 0 to read the table via t
    cyc(0, 0, 0, 1, ent(5, 0), dat(0, 1));
    cyc(0, 0, 1, 1, ent(0, 1), dat(7, 7));
    cyc(0, 0, 2, 1, ent(4, 0), dat(0, 2));
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);

    // write/step collision on the active entry
    cyc(0, 1, 1, 1, ent(0, 1), dat(2, 1));
    cyc(0, 0, 2, 1, ent(1, 2), dat(0, 5));
    cyc(0, 1, 2, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);

    // hold with en low
    repeat (5) cyc(0, 0, $urandom_range(0, 3), 0, 0, 0);

    // randomized mix of steps, writes (legal and illegal) and rare resets
    repeat (400) begin
      rr = ($urandom_range(0, 49) == 0) ? 1 : 0;
      re = $urandom_range(0, 1);
      rx = $urandom_range(0, 3);
      rw = ($urandom_range(0, 2) == 0) ? 1 : 0;
      ra = $urandom_range(0, 31);
      rn = ($urandom_range(0, 3) != 0) ? $urandom_range(0, NUM_ST-1) : $urandom_range(0, 7);
      cyc(rr[0], re[0], rx, rw[0], ra, dat(rn, $urandom_range(0, 7)));
    end

    // steps counter wrap
    cyc(1, 0, 0, 0, 0, 0);
    repeat (65535) cyc(0, 1, $urandom_range(0, 3), 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);

    // reset wins over concurrent writes, legal or illegal
    cyc(0, 0, 0, 1, ent(0, 0), dat(3, 7));
    cyc(0, 0, 1, 1, ent(0, 1), dat(2, 4));
    cyc(1, 1, 1, 1, ent(0, 1), dat(2, 5));
    for (int v = 0; v < NCOL; v++) cyc(0, 0, v, 0, 0, 0);
    cyc(1, 1, 0, 1, ent(6, 0), dat(0, 0));
    for (int v = 0; v < NCOL; v++) cyc(0, 0, v, 0, 0, 0);

    cyc(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #4;
    chk("sb_drain", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
